mileage_recorder: RTL and testbench

- Odometer accumulator feeding the 8-digit mileage display stage.
- Counts distance units while the car is powered and moving, and holds the value while stopped or powered off.
- Saturates at the 8-digit decimal maximum.
- Presents a registered 27-bit binary `record` that the display stage decomposes into decimal digits.

---
 rtl/mileage_recorder.sv | 121 ++++++++++++
 tb/tb_mileage_recorder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mileage_recorder.sv
// Odometer accumulator: counts distance units while powered and moving, holds
// otherwise, saturates at MAX_RECORD and supports a trip clear while stopped.
module mileage_recorder #(
    parameter int unsigned CLKS_PER_UNIT = 100_000_000,
    parameter int unsigned MAX_RECORD    = 99_999_999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        power_now,
    input  logic        moving,
    input  logic        clear_btn,
    output logic [26:0] record,
    output logic        unit_tick,
    output logic        saturated,
    output logic        running
);

    localparam int unsigned    PreW    = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;
    localparam logic [PreW-1:0] PreLast = PreW'(CLKS_PER_UNIT - 1);
    localparam logic [26:0]     MaxRec  = 27'(MAX_RECORD);

    typedef enum logic [1:0] {StOff, StStop, StRun} state_e;

    state_e          state_q, state_d;
    logic [PreW-1:0] presc_q, presc_d;
    logic [26:0]     record_q, record_d;
    logic            tick_q, tick_d;
    logic            sat_q, sat_d;
    logic            sync1_q, sync2_q;
    // Delayed copy of the synchronised button for rising-edge detection.
    logic            clear_dly_q;
    logic            clear_rise;
    logic            clear_apply;
    logic            wrap;

    // Button synchroniser and edge-detect register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            clear_dly_q <= 1'b0;
        end else begin
            sync1_q     <= clear_btn;
            sync2_q     <= sync1_q;
            clear_dly_q <= sync2_q;
        end
    end

    // Next state: power loss wins from any state, otherwise motion selects RUN/STOP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StOff, StStop, StRun: begin
                if (!power_now) begin
                    state_d = StOff;
                end else if (moving) begin
                    state_d = StRun;
                end else begin
                    state_d = StStop;
                end
            end
            default: state_d = StOff;
        endcase
    end

    // Prescaler, accumulator, saturation flag and tick next-state.
    always_comb begin
        clear_rise  = sync2_q & ~clear_dly_q;
        clear_apply = clear_rise && (state_q == StStop);
        wrap        = (state_q == StRun) && (presc_q == PreLast);

        presc_d  = presc_q;
        record_d = record_q;
        tick_d   = 1'b0;
        sat_d    = sat_q;

        if (state_q == StRun) begin
            presc_d = wrap ? '0 : presc_q + PreW'(1);
        end
        // Partial distance is dropped whenever the car ends up powered off.
        if (state_d == StOff) begin
            presc_d = '0;
        end

        if (wrap && (record_q < MaxRec)) begin
            record_d = record_q + 27'd1;
            tick_d   = 1'b1;
            sat_d    = (record_d == MaxRec);
        end

        // Clear only ever coincides with STOP, so it cannot collide with a wrap.
        if (clear_apply) begin
            record_d = '0;
            sat_d    = 1'b0;
            presc_d  = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StOff;
            presc_q  <= '0;
            record_q <= '0;
            tick_q   <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            presc_q  <= presc_d;
            record_q <= record_d;
            tick_q   <= tick_d;
            sat_q    <= sat_d;
        end
    end

    assign record    = record_q;
    assign unit_tick = tick_q;
    assign saturated = sat_q;
    assign running   = (state_q == StRun);

endmodule

// File: tb/tb_mileage_recorder.sv
// Directed bench for mileage_recorder with a scoreboard of expected ticks.
module tb_mileage_recorder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        power_now;
    logic        moving;
    logic        clear_btn;
    logic [26:0] record;
    logic        unit_tick;
    logic        saturated;
    logic        running;

    typedef struct {
        int unsigned rec;
        int unsigned cyc;
    } tick_t;

    tick_t       sb[$];
    int unsigned cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;

    mileage_recorder #(
        .CLKS_PER_UNIT(4),
        .MAX_RECORD   (12)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .power_now(power_now),
        .moving   (moving),
        .clear_btn(clear_btn),
        .record   (record),
        .unit_tick(unit_tick),
        .saturated(saturated),
        .running  (running)
    );

    always #5 clk = ~clk;

    // Posedge count; at a negedge it equals the number of edges seen so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_tick(input int unsigned rec, input int unsigned at);
        tick_t e;
        e.rec = rec;
        e.cyc = at;
        sb.push_back(e);
    endtask

    // Tick monitor: every tick must match the next scoreboard entry in value and cycle.
    always @(negedge clk) begin
        tick_t e;
        if (unit_tick === 1'b1) begin
            vectors++;
            assert (sb.size() > 0) else begin
                miscompares++;
                $error("FAIL spurious_tick: observed tick at cycle %0d expected none", cyc);
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("tick_record", 32'(record), e.rec);
                chk("tick_cycle", cyc, e.cyc);
            end
        end
        chk("saturated_flag", 32'(saturated), 32'(record == 27'd12));
    end

    initial begin
        int unsigned k;
        int unsigned j;
        int unsigned p;
        int unsigned c;

        // Reset while powered and moving.
        rst_n     = 1'b0;
        power_now = 1'b1;
        moving    = 1'b1;
        clear_btn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_record", 32'(record), 0);
        chk("reset_tick", 32'(unit_tick), 0);
        chk("reset_saturated", 32'(saturated), 0);
        chk("reset_running", 32'(running), 0);

        // Continuous run from reset release to saturation at 12.
        k     = cyc;
        rst_n = 1'b1;
        for (int i = 1; i <= 12; i++) push_tick(i, k + 1 + 4 * i);
        @(negedge clk);
        chk("run_enter", 32'(running), 1);
        repeat (40) @(negedge clk);
        chk("run_record10", 32'(record), 10);
        chk("run_running", 32'(running), 1);
        repeat (40) @(negedge clk);
        chk("sat_record", 32'(record), 12);
        chk("sat_flag", 32'(saturated), 1);

        // Clear while running is discarded.
        clear_btn = 1'b1;
        repeat (5) @(negedge clk);
        clear_btn = 1'b0;
        repeat (5) @(negedge clk);
        chk("clear_run_record", 32'(record), 12);

        // Power off holds the value and ignores clear.
        power_now = 1'b0;
        repeat (3) @(negedge clk);
        chk("off_running", 32'(running), 0);
        clear_btn = 1'b1;
        repeat (5) @(negedge clk);
        clear_btn = 1'b0;
        repeat (5) @(negedge clk);
        chk("clear_off_record", 32'(record), 12);
        chk("clear_off_sat", 32'(saturated), 1);

        // Clear in STOP takes effect on the third edge after the button rises.
        power_now = 1'b1;
        moving    = 1'b0;
        repeat (2) @(negedge clk);
        chk("stop_running", 32'(running), 0);
        clear_btn = 1'b1;
        repeat (2) @(negedge clk);
        chk("clear_stop_early", 32'(record), 12);
        @(negedge clk);
        chk("clear_stop_record", 32'(record), 0);
        chk("clear_stop_sat", 32'(saturated), 0);
        repeat (2) @(negedge clk);
        clear_btn = 1'b0;
        repeat (3) @(negedge clk);

        // Fresh reset, then stop/resume retention of partial distance.
        rst_n  = 1'b0;
        moving = 1'b1;
        repeat (2) @(negedge clk);
        k     = cyc;
        rst_n = 1'b1;
        push_tick(1, k + 5);
        repeat (6) @(negedge clk);
        moving = 1'b0;
        repeat (20) @(negedge clk);
        chk("stopped_record", 32'(record), 1);
        chk("stopped_running", 32'(running), 0);
        j      = cyc;
        moving = 1'b1;
        for (int i = 0; i < 4; i++) push_tick(2 + i, j + 3 + 4 * i);

        // Power cycle mid-count discards the partial unit.
        repeat (17) @(negedge clk);
        power_now = 1'b0;
        repeat (5) @(negedge clk);
        chk("pwroff_record", 32'(record), 5);
        chk("pwroff_running", 32'(running), 0);
        p         = cyc;
        power_now = 1'b1;
        push_tick(6, p + 5);
        push_tick(7, p + 9);

        // Moving falls on the same edge as a wrap: the increment still lands.
        repeat (8) @(negedge clk);
        moving = 1'b0;
        repeat (3) @(negedge clk);
        chk("wrapstop_record", 32'(record), 7);
        chk("wrapstop_running", 32'(running), 0);

        // Clear in STOP from record 7, then resume from a zero prescaler.
        c         = cyc;
        clear_btn = 1'b1;
        repeat (2) @(negedge clk);
        chk("clear7_early", 32'(record), 7);
        @(negedge clk);
        chk("clear7_record", 32'(record), 0);
        clear_btn = 1'b0;
        repeat (3) @(negedge clk);
        chk("clear7_hold", 32'(record), 0);
        k      = cyc;
        moving = 1'b1;
        push_tick(1, k + 5);
        repeat (5) @(negedge clk);
        chk("resume_record", 32'(record), 1);
        moving = 1'b0;
        repeat (6) @(negedge clk);
        chk("pending_ticks", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
